dice_roller: RTL and testbench

DICE_ROLLER -- requirements
Module: dice_roller

---
 rtl/dice_pkg.sv | 14 +
 rtl/die_counter.sv | 28 ++
 rtl/dice_roller.sv | 105 ++++++++++
 tb/tb_dice_roller.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// dice_pkg: shared state encoding and width/step helpers for the dice roller.
package dice_pkg;
   typedef enum logic [1:0] {IDLE, ROLLING, SETTLED, DONE} state_t;
   function automatic int dice_w(input int sides);
      return $clog2(sides + 1);
   endfunction
   function automatic int sum_w(input int n, input int sides);
      return $clog2(n * sides + 1);
   endfunction
   // Distinct per-die strides make the dice drift apart while the button is held.
   function automatic int step(input int i, input int sides);
      return (i % (sides - 1)) + 1;
   endfunction
endpackage

// File: rtl/die_counter.sv
// die_counter: one die, cycling 1..SIDES by a fixed stride; 0 means unrolled.
module die_counter
   import dice_pkg::*;
#(
   parameter int SIDES = 6,
   parameter int STEP = 1,
   localparam int DW = dice_w(SIDES)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          load1,
   input  logic          advance,
   output logic [DW-1:0] value
);
   logic [DW:0] acc;
   logic [DW-1:0] nxt;
   // acc = v-1+STEP stays below 2*SIDES, so one conditional subtract gives the modulo.
   always_comb begin
      acc = (DW+1)'(value) - (DW+1)'(1) + (DW+1)'(STEP);
      nxt = (acc >= (DW+1)'(SIDES)) ? DW'(acc - (DW+1)'(SIDES) + (DW+1)'(1)) : DW'(acc + (DW+1)'(1));
   end
   always_ff @(posedge clk) begin
      if (rst || clear) value <= '0;
      else if (load1) value <= DW'(1);
      else if (advance) value <= nxt;
   end
endmodule

// File: rtl/dice_roller.sv
// dice_roller: turn-based dice game controller with per-die hold and limited re-rolls.
module dice_roller
   import dice_pkg::*;
#(
   parameter int NUM_DICE = 5,
   parameter int SIDES = 6,
   parameter int MAX_ROLLS = 3,
   localparam int DW = dice_w(SIDES),
   localparam int SW = sum_w(NUM_DICE, SIDES)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   btn,
   input  logic                   new_turn,
   input  logic [NUM_DICE-1:0]    hold_mask,
   output logic [NUM_DICE*DW-1:0] dice,
   output logic [SW-1:0]          sum,
   output logic [2:0]             rolls_left,
   output logic                   choose,
   output logic                   turn_done
);
   localparam logic [2:0] MAXR = 3'(MAX_ROLLS);
   state_t state, state_n;
   logic btn_q, press, clear, load1;
   logic [NUM_DICE-1:0] mask, mask_n, adv;
   logic [2:0] rolls_n;
   assign press = btn & ~btn_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         btn_q <= 1'b0;
         mask <= '0;
         rolls_left <= MAXR;
      end else begin
         state <= state_n;
         btn_q <= btn;
         mask <= mask_n;
         rolls_left <= rolls_n;
      end
   end
   always_comb begin
      state_n = state;
      mask_n = mask;
      rolls_n = rolls_left;
      clear = 1'b0;
      load1 = 1'b0;
      adv = '0;
      if (!enable) begin
         state_n = IDLE;
         clear = 1'b1;
         rolls_n = MAXR;
      end else begin
         case (state)
            IDLE: begin
               clear = ~press;
               load1 = press;
               mask_n = press ? '0 : mask;
               state_n = press ? ROLLING : IDLE;
            end
            ROLLING: begin
               adv = btn ? ~mask : '0;
               rolls_n = btn ? rolls_left : rolls_left - 3'd1;
               state_n = btn ? ROLLING : (rolls_left == 3'd1 ? DONE : SETTLED);
            end
            SETTLED: begin
               // new_turn outranks a press; an all-held press is a no-op.
               if (new_turn) begin
                  state_n = IDLE;
                  clear = 1'b1;
                  rolls_n = MAXR;
               end else if (press && !(&hold_mask)) begin
                  state_n = ROLLING;
                  mask_n = hold_mask;
                  adv = ~hold_mask;
               end
            end
            DONE: begin
               if (new_turn) begin
                  state_n = IDLE;
                  clear = 1'b1;
                  rolls_n = MAXR;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end
   for (genvar i = 0; i < NUM_DICE; i++) begin : g_die
      die_counter #(.SIDES(SIDES), .STEP(step(i, SIDES))) u_die (
         .clk(clk),
         .rst(rst),
         .clear(clear),
         .load1(load1),
         .advance(adv[i]),
         .value(dice[i*DW +: DW])
      );
   end
   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_DICE; i++) sum = sum + SW'(dice[i*DW +: DW]);
   end
   assign choose = (state == SETTLED) || (state == DONE);
   assign turn_done = (state == DONE);
endmodule

// File: tb/tb_dice_roller.sv
// tb_dice_roller: directed scoreboard bench for dice_roller (5 dice, 6 sides, 3 rolls).
module tb_dice_roller;
   logic clk = 1'b0;
   logic rst, enable, btn, new_turn;
   logic [4:0] hold_mask;
   logic [14:0] dice;
   logic [4:0] sum;
   logic [2:0] rolls_left;
   logic choose, turn_done;
   int checks = 0;
   int failures = 0;
   typedef struct {
      string tag;
      int kind;
      logic [31:0] v;
   } exp_t;
   exp_t sb[$];

   dice_roller dut (
      .clk(clk), .rst(rst), .enable(enable), .btn(btn), .new_turn(new_turn),
      .hold_mask(hold_mask), .dice(dice), .sum(sum), .rolls_left(rolls_left),
      .choose(choose), .turn_done(turn_done)
   );

   always #5 clk = ~clk;

   function automatic logic [14:0] pk(input int a, input int b, input int c, input int d, input int e);
      return {3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
   endfunction

   task automatic want(input string t, input int k, input logic [31:0] v);
      exp_t e;
      e.tag = t;
      e.kind = k;
      e.v = v;
      sb.push_back(e);
   endtask

   task automatic want_all(input string t, input logic [14:0] d, input logic [2:0] r, input logic c, input logic td);
      int s = 0;
      for (int i = 0; i < 5; i++) s += int'(d[i*3 +: 3]);
      want({t, "_dice"}, 0, 32'(d));
      want({t, "_sum"}, 1, 32'(s));
      want({t, "_rolls"}, 2, 32'(r));
      want({t, "_choose"}, 3, 32'(c));
      want({t, "_done"}, 4, 32'(td));
   endtask

   task automatic drain();
      exp_t e;
      logic [31:0] o;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = e.kind == 0 ? 32'(dice) : e.kind == 1 ? 32'(sum) : e.kind == 2 ? 32'(rolls_left) :
             e.kind == 3 ? 32'(choose) : 32'(turn_done);
         checks++;
         assert (o === e.v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.v);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drain();
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; btn = 1'b0; new_turn = 1'b0; hold_mask = '0;
      want_all("reset", '0, 3'd3, 1'b0, 1'b0);
      tick();
      rst = 1'b0; enable = 1'b1; btn = 1'b1;
      want_all("first_load", pk(1, 1, 1, 1, 1), 3'd3, 1'b0, 1'b0);
      tick();
      tick(); tick(); tick();
      btn = 1'b0;
      want_all("first_roll", pk(4, 1, 4, 1, 4), 3'd2, 1'b1, 1'b0);
      tick();
      hold_mask = 5'b11111; btn = 1'b1;
      want_all("all_held_press", pk(4, 1, 4, 1, 4), 3'd2, 1'b1, 1'b0);
      tick();
      btn = 1'b0;
      want_all("all_held_release", pk(4, 1, 4, 1, 4), 3'd2, 1'b1, 1'b0);
      tick();
      hold_mask = 5'b00101; btn = 1'b1;
      want_all("partial_rolling", pk(4, 3, 4, 5, 3), 3'd2, 1'b0, 1'b0);
      tick();
      btn = 1'b0;
      want_all("partial_roll", pk(4, 3, 4, 5, 3), 3'd1, 1'b1, 1'b0);
      tick();
      hold_mask = 5'b00000; btn = 1'b1;
      tick();
      hold_mask = 5'b11111;
      want("mask_latched_dice", 0, 32'(pk(6, 1, 4, 1, 1)));
      tick();
      btn = 1'b0;
      want_all("third_roll", pk(6, 1, 4, 1, 1), 3'd0, 1'b1, 1'b1);
      tick();
      btn = 1'b1;
      tick();
      btn = 1'b0;
      want_all("done_ignores_btn", pk(6, 1, 4, 1, 1), 3'd0, 1'b1, 1'b1);
      tick();
      new_turn = 1'b1; btn = 1'b1;
      want_all("new_turn", '0, 3'd3, 1'b0, 1'b0);
      tick();
      new_turn = 1'b0; btn = 1'b0;
      want_all("idle_quiet", '0, 3'd3, 1'b0, 1'b0);
      tick();
      btn = 1'b1;
      want("idle_ignores_mask", 0, 32'(pk(1, 1, 1, 1, 1)));
      tick();
      want("second_turn_adv", 0, 32'(pk(2, 3, 4, 5, 6)));
      tick();
      enable = 1'b0;
      want_all("abort", '0, 3'd3, 1'b0, 1'b0);
      tick();
      enable = 1'b1;
      tick();
      want_all("held_btn_no_roll", '0, 3'd3, 1'b0, 1'b0);
      tick();
      btn = 1'b0;
      tick();
      btn = 1'b1;
      want_all("repress_load", pk(1, 1, 1, 1, 1), 3'd3, 1'b0, 1'b0);
      tick();
      btn = 1'b0;
      want_all("repress_settle", pk(1, 1, 1, 1, 1), 3'd2, 1'b1, 1'b0);
      tick();
      hold_mask = 5'b00000; btn = 1'b1;
      want("reroll_start", 0, 32'(pk(2, 3, 4, 5, 6)));
      tick();
      rst = 1'b1;
      want_all("rst_mid_roll", '0, 3'd3, 1'b0, 1'b0);
      tick();
      rst = 1'b0; btn = 1'b0;
      want_all("after_rst", '0, 3'd3, 1'b0, 1'b0);
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
